button_events: RTL and testbench

Parametrised, multi-channel successor to the single-button debounce, edge-to-reset and blink logic in the calculator top level. Each of `N_BUTTONS` raw asynchronous button inputs is synchronised and debounced, then turned into a stable level plus single-cycle press, release, long-press and auto-repeat event pulses. A free-running heartbeat output replaces the fixed 1 s blinker. The block sits between the board pins and the controller; the top level derives `internal_reset` and key events from its pulses.

---
 rtl/button_events_pkg.sv | 21 ++
 rtl/button_channel.sv | 141 ++++++++++++++
 rtl/button_events.sv | 70 +++++++
 tb/tb_button_events.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/button_events_pkg.sv
// Shared types and width helpers for the
// multi-channel button event block.
package button_events_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    HELD,
    LONG_HELD
  } btn_state_t;

  // Width able to hold 0..v; never below 1 bit.
  function automatic int cnt_w(input int v);
    return (v < 1) ? 1 : $clog2(v + 1);
  endfunction

  // Terminal count for a counter running 0..v-1.
  function automatic int last_val(input int v);
    return (v < 1) ? 0 : v - 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce and
// press / release / long / repeat event FSM.
module button_channel
  import button_events_pkg::*;
#(
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000
) (
  input  logic clock,
  input  logic internal_reset,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW = cnt_w(LONG_PRESS_CYCLES);
  localparam int RW = cnt_w(REPEAT_CYCLES);

  localparam logic [DW-1:0] DB_LAST =
    DW'(last_val(DEBOUNCE_CYCLES));
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(last_val(LONG_PRESS_CYCLES));
  localparam logic [RW-1:0] REP_LAST =
    RW'(last_val(REPEAT_CYCLES));

  logic          sync1_q, sync2_q;
  logic          pressed;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          level_q, level_d;
  logic          rise, fall;
  btn_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          long_q, long_d;
  logic          rep_evt_q, rep_evt_d;

  always_comb begin
    pressed  = sync2_q ^ ACTIVE_LOW;
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (pressed == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DW'(1);
    end
    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    rep_d     = rep_q;
    press_d   = 1'b0;
    rel_d     = 1'b0;
    long_d    = 1'b0;
    rep_evt_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (rise) begin
          state_d = HELD;
          hold_d  = '0;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
        end else if (hold_q == HOLD_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
          rep_d   = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      LONG_HELD: begin
        // Release wins over a repeat due in the same cycle.
        if (fall) begin
          state_d = RELEASED;
          rel_d   = 1'b1;
        end else if (REPEAT_CYCLES > 0) begin
          if (rep_q == REP_LAST) begin
            rep_evt_d = 1'b1;
            rep_d     = '0;
          end else begin
            rep_d = rep_q + RW'(1);
          end
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      sync1_q   <= ACTIVE_LOW;
      sync2_q   <= ACTIVE_LOW;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= RELEASED;
      hold_q    <= '0;
      rep_q     <= '0;
      press_q   <= 1'b0;
      rel_q     <= 1'b0;
      long_q    <= 1'b0;
      rep_evt_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hold_q    <= hold_d;
      rep_q     <= rep_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      long_q    <= long_d;
      rep_evt_q <= rep_evt_d;
    end
  end

  assign level       = level_q;
  assign press       = press_q;
  assign release_evt = rel_q;
  assign long_press  = long_q;
  assign repeat_evt  = rep_evt_q;

endmodule

// File: rtl/button_events.sv
// N debounced button channels with event pulses,
// plus a free-running heartbeat square wave.
module button_events
  import button_events_pkg::*;
#(
  parameter int N_BUTTONS         = 4,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int REPEAT_CYCLES     = 10000000,
  parameter int HEARTBEAT_HALF    = 25000000
) (
  input  logic                 clock,
  input  logic                 internal_reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_evt,
  output logic [N_BUTTONS-1:0] long_press,
  output logic [N_BUTTONS-1:0] repeat_evt,
  output logic                 heartbeat
);

  localparam int HBW = cnt_w(HEARTBEAT_HALF);
  localparam logic [HBW-1:0] HB_LAST =
    HBW'(last_val(HEARTBEAT_HALF));

  logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
  logic           hb_q, hb_d;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW       (ACTIVE_LOW),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clock         (clock),
      .internal_reset(internal_reset),
      .btn_raw       (btn_raw[i]),
      .level         (level[i]),
      .press         (press[i]),
      .release_evt   (release_evt[i]),
      .long_press    (long_press[i]),
      .repeat_evt    (repeat_evt[i])
    );
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + HBW'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_ff @(posedge clock) begin
    if (internal_reset) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign heartbeat = hb_q;

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: event tables,
// directed corner cases and random stimulus vs a model.
module tb_button_events;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int LP = 20;
  localparam int RP = 5;
  localparam int HH = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] raw;
  logic [N-1:0] level, press, rel, lng, rep;
  logic         hb;

  always #5 clk = ~clk;

  button_events #(
    .N_BUTTONS        (N),
    .ACTIVE_LOW       (1'b1),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(LP),
    .REPEAT_CYCLES    (RP),
    .HEARTBEAT_HALF   (HH)
  ) dut (
    .clock         (clk),
    .internal_reset(rst),
    .btn_raw       (raw),
    .level         (level),
    .press         (press),
    .release_evt   (rel),
    .long_press    (lng),
    .repeat_evt    (rep),
    .heartbeat     (hb)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: run-length debounce and cycles-since-press.
  int m_run[N];
  bit m_lvl[N];
  bit m_s1[N];
  bit m_s2[N];
  bit m_held[N];
  int m_since[N];
  int m_hbc;
  logic [N-1:0] e_lvl, e_press, e_rel, e_long, e_rep;
  logic         e_hb;

  int n_press[N], n_rel[N], n_long[N], n_rep[N];
  int t_press[N], t_rel[N], t_long[N];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d",
               name, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    e_rep   = '0;
    if (rst) begin
      m_hbc = 0;
      for (int c = 0; c < N; c++) begin
        m_run[c] = 0; m_lvl[c] = 0;
        m_s1[c] = 1; m_s2[c] = 1;
        m_held[c] = 0; m_since[c] = 0;
      end
    end else begin
      m_hbc++;
      for (int c = 0; c < N; c++) begin
        bit p, rise, fall;
        p = ~m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
        rise = 0;
        fall = 0;
        if (p != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_lvl[c] = p;
            m_run[c] = 0;
            rise = p;
            fall = !p;
          end
        end else begin
          m_run[c] = 0;
        end
        if (rise) begin
          e_press[c] = 1; m_held[c] = 1; m_since[c] = 0;
        end else if (fall) begin
          e_rel[c] = 1; m_held[c] = 0;
        end else if (m_held[c]) begin
          m_since[c]++;
          if (m_since[c] == LP) e_long[c] = 1;
          else if (RP > 0 && m_since[c] > LP &&
                   (m_since[c] - LP) % RP == 0) e_rep[c] = 1;
        end
      end
    end
    for (int c = 0; c < N; c++) e_lvl[c] = m_lvl[c];
    e_hb = ((m_hbc / HH) % 2) == 1;
  endtask

  task automatic clr_stats();
    for (int c = 0; c < N; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
      t_press[c] = -1; t_rel[c] = -1; t_long[c] = -1;
    end
  endtask

  task automatic tick();
    logic [5*N:0] got, exp;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    got = {level, press, rel, lng, rep, hb};
    exp = {e_lvl, e_press, e_rel, e_long, e_rep, e_hb};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL model_cmp cyc=%0d got=%b expected=%b",
               cyc, got, exp);
    end
    for (int c = 0; c < N; c++) begin
      int k;
      k = int'(press[c]) + int'(rel[c]) + int'(lng[c]) + int'(rep[c]);
      if (k > 1) chk("one_event", k, 1);
      if (press[c]) begin n_press[c]++; t_press[c] = cyc; end
      if (rel[c])   begin n_rel[c]++;   t_rel[c] = cyc;   end
      if (lng[c])   begin n_long[c]++;  t_long[c] = cyc;  end
      if (rep[c])   n_rep[c]++;
    end
  endtask

  typedef struct {
    int ch;
    int low;
    int pr;
    int rl;
    int lg;
    int rp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0;
    logic [11:0] hbv;

    vecs[0] = '{0, 10,  6, 16, -1, 0};
    vecs[1] = '{0,  3, -1, -1, -1, 0};
    vecs[2] = '{0,  4,  6, 10, -1, 0};
    vecs[3] = '{1, 40,  6, 46, 26, 3};
    vecs[4] = '{1,  2, -1, -1, -1, 0};
    vecs[5] = '{1, 25,  6, 31, 26, 0};
    vecs[6] = '{0, 20,  6, 26, -1, 0};

    rst = 1'b1;
    raw = '1;
    clr_stats();
    repeat (3) tick();
    chk("reset_outs", int'({level, press, rel, lng, rep, hb}), 0);
    rst = 1'b0;

    hbv = '0;
    for (int k = 0; k < 12; k++) begin
      tick();
      hbv[k] = hb;
    end
    chk("heartbeat_seq", int'(hbv), 'h71C);

    foreach (vecs[i]) begin
      clr_stats();
      t0 = cyc;
      raw[vecs[i].ch] = 1'b0;
      repeat (vecs[i].low) tick();
      raw[vecs[i].ch] = 1'b1;
      repeat (14) tick();
      chk($sformatf("v%0d_npress", i), n_press[vecs[i].ch],
          vecs[i].pr >= 0 ? 1 : 0);
      chk($sformatf("v%0d_nrel", i), n_rel[vecs[i].ch],
          vecs[i].rl >= 0 ? 1 : 0);
      chk($sformatf("v%0d_nlong", i), n_long[vecs[i].ch],
          vecs[i].lg >= 0 ? 1 : 0);
      chk($sformatf("v%0d_nrep", i), n_rep[vecs[i].ch], vecs[i].rp);
      chk($sformatf("v%0d_other", i), n_press[1 - vecs[i].ch], 0);
      if (vecs[i].pr >= 0)
        chk($sformatf("v%0d_tpress", i), t_press[vecs[i].ch] - t0,
            vecs[i].pr);
      if (vecs[i].rl >= 0)
        chk($sformatf("v%0d_trel", i), t_rel[vecs[i].ch] - t0,
            vecs[i].rl);
      if (vecs[i].lg >= 0)
        chk($sformatf("v%0d_tlong", i), t_long[vecs[i].ch] - t0,
            vecs[i].lg);
    end

    // Both channels pressed together.
    clr_stats();
    t0 = cyc;
    raw = '0;
    repeat (8) tick();
    chk("both_press0", t_press[0] - t0, 6);
    chk("both_press1", t_press[1] - t0, 6);
    raw = '1;
    repeat (12) tick();

    // Reset while ch0 is long-held and still low.
    clr_stats();
    raw[0] = 1'b0;
    repeat (30) tick();
    chk("pre_rst_long", n_long[0], 1);
    rst = 1'b1;
    tick();
    chk("rst_level", int'(level), 0);
    rst = 1'b0;
    clr_stats();
    t0 = cyc;
    repeat (10) tick();
    chk("rst_no_rel", n_rel[0], 0);
    chk("rst_repress", t_press[0] - t0, 6);
    raw[0] = 1'b1;
    repeat (12) tick();

    // Random stimulus against the model.
    for (int s = 0; s < 200; s++) begin
      raw = N'($urandom);
      rst = ($urandom_range(0, 30) == 0);
      tick();
      rst = 1'b0;
      repeat ($urandom_range(1, 30)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
